uart_rx_16x: RTL and testbench
==============================

Name: uart_rx_16x

Overview:
- UART receiver that consumes the baud_tick_16x strobe from baud_gen_16x and oversamples the serial line at 16x.
- Recovers 8N1 frames: LSB first, one start bit, one stop bit.
- Presents each received byte on a valid/ready output port, with framing-error and overrun flags.
- Sits between the rx pad and the host-side byte consumer; it is the receive-side counterpart of the tick generator/TX path.

Parameters:
- DATA_BITS, 8: data bits per frame (legal range 5..8).
- SYNC_STAGES, 2: number of flops in the rx input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- baud_tick_16x  in  1  one-clk-wide strobe at 16x the baud rate.
- rx  in  1  asynchronous serial input; idles high.
- rx_data  out  DATA_BITS  received byte, LSB = first bit on the wire.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  out  1  qualifies rx_data; the stop bit of this byte was sampled low.
- overrun  out  1  one-clk pulse; a completed frame was dropped.

Behaviour:
- Reset (async, rst=1): state IDLE, tick_cnt=0, bit_cnt=0, shift=0, synchronizer flops=1, rx_data=0, rx_valid=0, frame_err=0, overrun=0.
- All state advances occur only on clk edges where baud_tick_16x=1. The output handshake is evaluated every clk.
- rx passes through SYNC_STAGES flops to give rx_s. rx_prev is rx_s registered on each tick.
- State IDLE:
  - On a tick with rx_prev=1 and rx_s=0 (falling edge): go to START, tick_cnt=0.
  - A line held low (break) never re-arms until rx returns high.
- State START: tick_cnt increments per tick. At tick_cnt=7 (mid start bit):
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: glitch; return to IDLE.
- State DATA:
  - Sample rx_s at tick_cnt=15, i.e. the middle of each bit.
  - Shift right into shift[DATA_BITS-1]; tick_cnt wraps to 0.
  - After the sample at bit_cnt=DATA_BITS-1, go to STOP (or PARITY when the parity feature is compiled in).
- State STOP: at tick_cnt=15, sample the stop bit, perform the delivery below, then return to IDLE.
- Delivery, on the clk of the stop-bit sample:
  - Output empty (rx_valid=0), or rx_ready=1 in the same clk: rx_data<=shift, frame_err<=~rx_s, rx_valid<=1 next clk. Latency is 1 clk after the stop-sample tick.
  - Output full (rx_valid=1) and rx_ready=0: the new byte is discarded, the held byte is kept, overrun pulses for 1 clk.
- Consumption: rx_valid && rx_ready with no simultaneous delivery clears rx_valid and frame_err next clk.
- A frame with frame_err=1 is still delivered; the consumer decides what to do with it.
- rst asserted mid-frame aborts immediately. After rst releases, the partial frame is not resumed; the next falling edge starts a new frame.
- Counter widths: tick_cnt is 4 bits, wraps 15 to 0. bit_cnt is $clog2(DATA_BITS) bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A parity bit follows the data bits, and state PARITY samples it at tick_cnt=15.
  - Added parameter PARITY_ODD, default 0 (even parity).
  - Added output parity_err (1 bit), which qualifies rx_data with the same timing and clear rules as frame_err.
  - Frame length becomes 1+DATA_BITS+1+1.
- Undefined: no PARITY state, no PARITY_ODD, no parity_err port. The frame is 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - OVERSAMPLE=16, MID_SAMPLE=7, LAST_TICK=15.
- Natural sub-module: uart_sync, a SYNC_STAGES-deep synchronizer whose reset value is 1. Reused by the TX/CTS paths.

Test Plan:
- Bench drives baud_tick_16x every 4 clk (1 bit = 64 clk). Send 0xA5 with a valid stop bit -> rx_valid rises 1 clk after the stop-sample tick; rx_data=0xA5, frame_err=0.
- Low glitch of 3 ticks while IDLE -> returns to IDLE at the mid-start check; rx_valid stays 0. A following 0x3C frame is received correctly.
- Send 0x55 with the stop bit driven low -> rx_data=0x55, frame_err=1. With rx held low afterwards, no new frame starts until rx goes high.
- Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses 1 clk at the second stop sample. Raise rx_ready and send 0x33 -> 0x11 consumed, then 0x33 delivered.
- rx_ready=1 in the same clk that 0x77 completes while 0x66 is held -> 0x66 is consumed, 0x77 is loaded, no overrun.
- Assert rst mid-DATA of a frame, then release -> all outputs are 0 during rst; the next full frame 0xF0 is received cleanly.
- With UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity=0 -> parity_err=1; send 0x07 with parity=1 -> parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART blocks: receiver state
// encoding and the oversampling tick positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] MID_SAMPLE = TICK_W'(7);
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for asynchronous serial lines. Resets to 1 so an
// idle-high line never looks like a start edge coming out of reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_16x.sv
// 16x-oversampling UART receiver with a valid/ready byte output, framing-error
// and overrun flags. Define UART_RX_PARITY_EN to add a parity bit and parity_err.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic rx_s;
  logic rx_prev_q;

  state_e                 state_q, state_d;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   stop_sample;

  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   parity_err_q, parity_err_d;
`endif

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_prev_q    <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
      if (baud_tick_16x) begin
        rx_prev_q <= rx_s;
      end
    end
  end

  // Frame sequencing; every counter moves only on an oversampling tick.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d   = par_bit_q;
`endif
    if (baud_tick_16x) begin
      case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          if (tick_cnt_q == MID_SAMPLE) begin
            if (!rx_s) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        DATA: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == LAST_TICK) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == LAST_TICK) begin
            par_bit_d = rx_s;
            state_d   = STOP;
          end
        end
`endif
        STOP: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == LAST_TICK) begin
            stop_sample = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completed frame replaces the held byte only if the slot is empty or
  // being drained in the same clk; otherwise it is dropped and flagged.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (stop_sample) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        frame_err_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (^{shift_q, par_bit_q}) ^ PARITY_ODD;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_16x.sv
// Self-checking bench for uart_rx_16x: directed frames plus randomized traffic,
// compared every clk against a tick-indexed frame model of the receiver.
module tb_uart_rx_16x;

  localparam int DATA_BITS = 8;
  localparam int BIT_CLKS  = 64;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  // Ticks from the detected start edge to the stop-bit sample.
  localparam int STOP_TICK = 8 + 16 * (DATA_BITS + PAR_BITS + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 baud_tick_16x = 1'b0;
  logic                 rx = 1'b1;
  logic                 rx_ready = 1'b0;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  int checks = 0;
  int failures = 0;
  int overrunCount = 0;
  int tickDiv = 0;
  bit readyRandom = 1'b0;

  uart_rx_16x dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick_16x (baud_tick_16x),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_err     (frame_err),
    .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_err  (parity_err)
`endif
  );

  initial forever #5 clk = ~clk;

  // One tick every 4 clk, changed on the falling edge.
  initial forever begin
    @(negedge clk);
    tickDiv = (tickDiv + 1) % 4;
    baud_tick_16x = (tickDiv == 0);
  end

  initial forever begin
    @(negedge clk);
    if (readyRandom) rx_ready = 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge clk);
    if (overrun === 1'b1) overrunCount++;
  end

  // Frame model: the line as seen after two sync flops, with sample points
  // placed by tick count from the detected start edge.
  logic                 mHist [2];
  logic                 mPrevS;
  bit                   mInFrame;
  int                   mN;
  logic [DATA_BITS-1:0] mBits;
  logic                 mPar;
  logic [DATA_BITS-1:0] expData;
  logic                 expValid, expFerr, expOverrun, expPerr;

  function automatic void resetModel();
    mHist[0] = 1'b1; mHist[1] = 1'b1;
    mPrevS = 1'b1; mInFrame = 1'b0; mN = 0;
    mBits = '0; mPar = 1'b0;
    expData = '0; expValid = 1'b0; expFerr = 1'b0;
    expOverrun = 1'b0; expPerr = 1'b0;
  endfunction

  function automatic void stepModel();
    logic rxS;
    bit   deliver;
    logic stopBit;
    int   k;
    rxS      = mHist[1];
    mHist[1] = mHist[0];
    mHist[0] = rx;
    deliver  = 1'b0;
    stopBit  = 1'b1;
    if (baud_tick_16x) begin
      if (!mInFrame) begin
        if (mPrevS && !rxS) begin
          mInFrame = 1'b1;
          mN = 0;
        end
      end else begin
        mN++;
        if (mN == 8) begin
          if (rxS) mInFrame = 1'b0;
        end else if (mN > 8 && (mN - 8) % 16 == 0) begin
          k = (mN - 8) / 16 - 1;
          if (k < DATA_BITS) mBits[k] = rxS;
          else if (k < DATA_BITS + PAR_BITS) mPar = rxS;
          else begin
            stopBit  = rxS;
            deliver  = 1'b1;
            mInFrame = 1'b0;
          end
        end
      end
      mPrevS = rxS;
    end
    expOverrun = 1'b0;
    if (deliver) begin
      if (!expValid || rx_ready) begin
        expData  = mBits;
        expValid = 1'b1;
        expFerr  = !stopBit;
        expPerr  = ((($countones(mBits) + int'(mPar)) % 2) != 0);
      end else begin
        expOverrun = 1'b1;
      end
    end else if (expValid && rx_ready) begin
      expValid = 1'b0;
      expFerr  = 1'b0;
      expPerr  = 1'b0;
    end
  endfunction

  initial begin
    resetModel();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) resetModel();
      else stepModel();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    checkOutput("cyc_rx_valid",  32'(rx_valid),  32'(expValid));
    checkOutput("cyc_rx_data",   32'(rx_data),   32'(expData));
    checkOutput("cyc_frame_err", 32'(frame_err), 32'(expFerr));
    checkOutput("cyc_overrun",   32'(overrun),   32'(expOverrun));
`ifdef UART_RX_PARITY_EN
    checkOutput("cyc_parity_err", 32'(parity_err), 32'(expPerr));
`endif
  end

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parBit);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (PAR_BITS != 0) begin
      rx = parBit;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stopBit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic sendGood(input logic [7:0] data);
    applyStimulus(data, 1'b1, ^data);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic readyAtStopSample();
    int   cnt;
    logic [7:0] pat;
    cnt = 0;
    pat = 8'h77;
    fork
      sendGood(pat);
      begin
        while (cnt < 2000 && !(mInFrame && mN == STOP_TICK - 1 && tickDiv == 3)) begin
          @(posedge clk);
          #1;
          cnt++;
        end
        checks++;
        if (cnt >= 2000) begin
          failures++;
          $display("[TB] FAIL stop_wait: got timeout, expected stop-sample window at %0t", $time);
        end else begin
          @(negedge clk);
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
        end
      end
    join
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] partial;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_data",  32'(rx_data),  32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] clean frame 0xA5");
    sendGood(8'hA5);
    repeat (20) @(negedge clk);
    checkOutput("a5_data",  32'(rx_data),   32'hA5);
    checkOutput("a5_valid", 32'(rx_valid),  32'd1);
    checkOutput("a5_ferr",  32'(frame_err), 32'd0);
    checkOutput("model_a5", 32'(expData),   32'hA5);
    consume();
    checkOutput("a5_consumed", 32'(rx_valid), 32'd0);

    $display("[TB] start-bit glitch then 0x3C");
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("glitch_valid", 32'(rx_valid), 32'd0);
    sendGood(8'h3C);
    repeat (20) @(negedge clk);
    checkOutput("3c_data", 32'(rx_data), 32'h3C);
    consume();

    $display("[TB] framing error 0x55 then break");
    applyStimulus(8'h55, 1'b0, ^8'h55);
    repeat (20) @(negedge clk);
    checkOutput("55_data",       32'(rx_data),   32'h55);
    checkOutput("55_ferr",       32'(frame_err), 32'd1);
    checkOutput("model_55_ferr", 32'(expFerr),   32'd1);
    consume();
    repeat (3 * BIT_CLKS) @(negedge clk);
    checkOutput("break_valid", 32'(rx_valid), 32'd0);
    rx = 1'b1;
    repeat (100) @(negedge clk);

    $display("[TB] overrun 0x11/0x22 then 0x33");
    sendGood(8'h11);
    sendGood(8'h22);
    repeat (20) @(negedge clk);
    checkOutput("ovr_data",  32'(rx_data),   32'h11);
    checkOutput("ovr_count", 32'(overrunCount), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    checkOutput("ovr_consumed", 32'(rx_valid), 32'd0);
    sendGood(8'h33);
    repeat (20) @(negedge clk);
    checkOutput("33_data",  32'(rx_data),  32'h33);
    checkOutput("33_valid", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    $display("[TB] consume 0x66 in the clk 0x77 completes");
    sendGood(8'h66);
    repeat (20) @(negedge clk);
    checkOutput("66_data", 32'(rx_data), 32'h66);
    readyAtStopSample();
    repeat (20) @(negedge clk);
    checkOutput("77_data",     32'(rx_data),      32'h77);
    checkOutput("77_valid",    32'(rx_valid),     32'd1);
    checkOutput("77_no_ovr",   32'(overrunCount), 32'd1);

    $display("[TB] reset mid-frame then 0xF0");
    partial = 8'h9A;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = partial[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("rst_valid", 32'(rx_valid),  32'd0);
    checkOutput("rst_data",  32'(rx_data),   32'd0);
    checkOutput("rst_ferr",  32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    sendGood(8'hF0);
    repeat (20) @(negedge clk);
    checkOutput("f0_data",  32'(rx_data),   32'hF0);
    checkOutput("f0_ferr",  32'(frame_err), 32'd0);
    checkOutput("f0_valid", 32'(rx_valid),  32'd1);
    consume();

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity checks on 0x07");
    applyStimulus(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("par0_err", 32'(parity_err), 32'd1);
    consume();
    applyStimulus(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("par1_err", 32'(parity_err), 32'd0);
    consume();
`endif

    $display("[TB] randomized traffic");
    readyRandom = 1'b1;
    for (int n = 0; n < 12; n++) begin
      rx = 1'b1;
      repeat ($urandom_range(0, 150)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
      end
      d = 8'($urandom);
      applyStimulus(d, ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)));
    end
    rx = 1'b1;
    repeat (300) @(negedge clk);
    readyRandom = 1'b0;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
